// File: rtl/ts_capture_queue_if.sv
// ---------------------------------------------------------------------------
// ts_capture_queue_if
// Read-side stream of the timestamp capture queue.
//   rd_valid : FIFO head holds a captured timestamp
//   rd_ready : consumer accepts the head this cycle
//   rd_data  : captured timestamp at the FIFO head
//   rd_ovf   : head entry is the first accepted after dropped events
//              (only present when TSQ_OVF_MARK_EN is defined)
// Modports: master = queue side (drives valid/data), slave = consumer side.
// ---------------------------------------------------------------------------
interface ts_capture_queue_if #(
    parameter int TS_BITS = 30
);
    logic               rd_valid;
    logic               rd_ready;
    logic [TS_BITS-1:0] rd_data;
`ifdef TSQ_OVF_MARK_EN
    logic               rd_ovf;
`endif

    modport master (
        output rd_valid,
        output rd_data,
`ifdef TSQ_OVF_MARK_EN
        output rd_ovf,
`endif
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
`ifdef TSQ_OVF_MARK_EN
        input  rd_ovf,
`endif
        output rd_ready
    );
endinterface

// File: rtl/ts_capture_queue.sv
// ---------------------------------------------------------------------------
// ts_capture_queue
// Timestamp capture queue. Every evt_strobe latches ts_current into a local
// show-ahead FIFO which the host drains through a ready/valid stream. Also
// keeps overflow/fill statistics and a data-available interrupt handshake.
// Everything lives in the ts_clk domain.
//
// Ports:
//   ts_clk      sole clock
//   ts_reset_n  asynchronous active-low reset
//   ts_current  free-running timestamp
//   evt_strobe  single-cycle capture request (no backpressure)
//   rd          read stream (ts_capture_queue_if.master)
//   stat_clr    clears the overflow counter
//   stat_data   {ovf_cnt[7:0], zeros, count[QUEUE_BITS:0]}
//   int_ready   interrupt acknowledge
//   int_valid   data-available interrupt request
//
// Optional feature macro: TSQ_OVF_MARK_EN
//   Adds a mark bit per entry, presented as rd.rd_ovf, flagging the first
//   entry accepted after one or more dropped events.
// ---------------------------------------------------------------------------
module ts_capture_queue #(
    parameter int TS_BITS    = 30,
    parameter int QUEUE_BITS = 5
) (
    input  logic                ts_clk,
    input  logic                ts_reset_n,
    input  logic [TS_BITS-1:0]  ts_current,
    input  logic                evt_strobe,
    ts_capture_queue_if.master  rd,
    input  logic                stat_clr,
    output logic [31:0]         stat_data,
    input  logic                int_ready,
    output logic                int_valid
);

    localparam int DEPTH = 1 << QUEUE_BITS;
`ifdef TSQ_OVF_MARK_EN
    localparam int ENTRY_W = TS_BITS + 1;
`else
    localparam int ENTRY_W = TS_BITS;
`endif
    localparam logic [QUEUE_BITS:0] FULL_CNT = {1'b1, {QUEUE_BITS{1'b0}}};
    localparam logic [QUEUE_BITS:0] PTR_ONE  = {{QUEUE_BITS{1'b0}}, 1'b1};

    logic [ENTRY_W-1:0]  mem [DEPTH];

    logic [QUEUE_BITS:0] wptr_q, wptr_d;
    logic [QUEUE_BITS:0] rptr_q, rptr_d;
    logic                rd_valid_q, rd_valid_d;
    logic                int_valid_q, int_valid_d;
    logic [7:0]          ovf_cnt_q, ovf_cnt_d;
`ifdef TSQ_OVF_MARK_EN
    logic                ovf_pend_q, ovf_pend_d;
`endif

    logic [QUEUE_BITS:0] cnt_cur;
    logic [QUEUE_BITS:0] cnt_nxt;
    logic                full;
    logic                pop;
    logic                wr_en;
    logic                drop;
    logic                int_set;
    logic [ENTRY_W-1:0]  wr_entry;
    logic [ENTRY_W-1:0]  head;

    always_comb begin
        cnt_cur     = wptr_q - rptr_q;
        full        = (cnt_cur == FULL_CNT);
        pop         = rd_valid_q & rd.rd_ready;
        // A full queue still accepts when the head leaves in the same cycle.
        wr_en       = evt_strobe & (~full | pop);
        drop        = evt_strobe & ~wr_en;

        wptr_d      = wr_en ? (wptr_q + PTR_ONE) : wptr_q;
        rptr_d      = pop   ? (rptr_q + PTR_ONE) : rptr_q;
        cnt_nxt     = wptr_d - rptr_d;
        rd_valid_d  = (cnt_nxt != '0);

        // Set has priority over acknowledge.
        int_set     = (cnt_cur == '0) && (cnt_nxt != '0);
        int_valid_d = int_set | (int_valid_q & ~int_ready);

        // Clear and drop in the same cycle leaves one counted drop.
        if (stat_clr) begin
            ovf_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end else begin
            ovf_cnt_d = ovf_cnt_q;
        end

`ifdef TSQ_OVF_MARK_EN
        wr_entry = {ovf_pend_q, ts_current};
        if (wr_en) begin
            ovf_pend_d = 1'b0;
        end else if (drop) begin
            ovf_pend_d = 1'b1;
        end else begin
            ovf_pend_d = ovf_pend_q;
        end
`else
        wr_entry = ts_current;
`endif
    end

    always_ff @(posedge ts_clk or negedge ts_reset_n) begin
        if (!ts_reset_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            rd_valid_q  <= 1'b0;
            int_valid_q <= 1'b0;
            ovf_cnt_q   <= '0;
`ifdef TSQ_OVF_MARK_EN
            ovf_pend_q  <= 1'b0;
`endif
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rd_valid_q  <= rd_valid_d;
            int_valid_q <= int_valid_d;
            ovf_cnt_q   <= ovf_cnt_d;
`ifdef TSQ_OVF_MARK_EN
            ovf_pend_q  <= ovf_pend_d;
`endif
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge ts_clk) begin
        if (wr_en) begin
            mem[wptr_q[QUEUE_BITS-1:0]] <= wr_entry;
        end
    end

    always_comb begin
        head        = mem[rptr_q[QUEUE_BITS-1:0]];
        rd.rd_valid = rd_valid_q;
        // Gate the head so an empty queue never exposes stale storage.
        rd.rd_data  = rd_valid_q ? head[TS_BITS-1:0] : '0;
`ifdef TSQ_OVF_MARK_EN
        rd.rd_ovf   = rd_valid_q & head[TS_BITS];
`endif
        int_valid   = int_valid_q;

        stat_data                = '0;
        stat_data[31:24]         = ovf_cnt_q;
        stat_data[QUEUE_BITS:0]  = cnt_cur;
    end

endmodule
